// File: rtl/pipeline_divider_rv.sv
// pipeline_divider_rv: fully pipelined restoring divider with valid/ready flow control and tag passthrough.
// Signed operation is compiled in only when DIV_SIGNED_EN is defined.
module pipeline_divider_rv #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 8,
  parameter int TAG_W  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_dividend,
  input  logic [WIDTH-1:0] in_divisor,
  input  logic             in_signed,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_quotient,
  output logic [WIDTH-1:0] out_remainder,
  output logic             out_div_by_zero,
  output logic [TAG_W-1:0] out_tag
);
  localparam int IPS = WIDTH / STAGES;

  if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_param_check
    $error("pipeline_divider_rv: STAGES must divide WIDTH and lie in 1..WIDTH");
  end

  // Stage k registers hold the operands entering that stage's iterations.
  logic             v_q [STAGES];
  logic [WIDTH-1:0] a_q [STAGES];
  logic [WIDTH-1:0] b_q [STAGES];
  logic [WIDTH-1:0] q_q [STAGES];
  logic [WIDTH-1:0] n_q [STAGES];
  logic [WIDTH:0]   r_q [STAGES];
  logic [TAG_W-1:0] t_q [STAGES];
  logic             z_q [STAGES];
`ifdef DIV_SIGNED_EN
  logic             nq_q [STAGES];
  logic             nr_q [STAGES];
  logic             sa0_d, sb0_d;
`endif

  logic [WIDTH-1:0] a_c [STAGES];
  logic [WIDTH-1:0] q_c [STAGES];
  logic [WIDTH:0]   r_c [STAGES];

  logic [WIDTH-1:0] a0_d, b0_d, q_fix_d, r_fix_d;

  logic             out_v_q, dbz_q;
  logic [WIDTH-1:0] quot_q, rem_q;
  logic [TAG_W-1:0] tag_q;

  logic stall;
  assign stall    = out_v_q && !out_ready;
  assign in_ready = !stall;

  always_comb begin
    a0_d = in_dividend;
    b0_d = in_divisor;
`ifdef DIV_SIGNED_EN
    sa0_d = in_signed & in_dividend[WIDTH-1];
    sb0_d = in_signed & in_divisor[WIDTH-1];
    if (sa0_d) a0_d = -in_dividend;
    if (sb0_d) b0_d = -in_divisor;
`endif
  end

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      a_c[k] = a_q[k];
      r_c[k] = r_q[k];
      q_c[k] = q_q[k];
      for (int j = 0; j < IPS; j++) begin
        r_c[k] = {r_c[k][WIDTH-1:0], a_c[k][WIDTH-1]};
        a_c[k] = a_c[k] << 1;
        if (r_c[k] >= {1'b0, b_q[k]}) begin
          r_c[k] = r_c[k] - {1'b0, b_q[k]};
          q_c[k] = (q_c[k] << 1) | WIDTH'(1'b1);
        end else begin
          q_c[k] = q_c[k] << 1;
        end
      end
    end
  end

  // Divide-by-zero overrides everything, including the signed fix-up.
  always_comb begin
    q_fix_d = q_c[STAGES-1];
    r_fix_d = r_c[STAGES-1][WIDTH-1:0];
`ifdef DIV_SIGNED_EN
    if (nq_q[STAGES-1]) q_fix_d = -q_fix_d;
    if (nr_q[STAGES-1]) r_fix_d = -r_fix_d;
`endif
    if (z_q[STAGES-1]) begin
      q_fix_d = '1;
      r_fix_d = n_q[STAGES-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k] <= 1'b0;
        a_q[k] <= '0;
        b_q[k] <= '0;
        q_q[k] <= '0;
        n_q[k] <= '0;
        r_q[k] <= '0;
        t_q[k] <= '0;
        z_q[k] <= 1'b0;
`ifdef DIV_SIGNED_EN
        nq_q[k] <= 1'b0;
        nr_q[k] <= 1'b0;
`endif
      end
      out_v_q <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      tag_q   <= '0;
    end else if (!stall) begin
      v_q[0] <= in_valid;
      a_q[0] <= a0_d;
      b_q[0] <= b0_d;
      q_q[0] <= '0;
      n_q[0] <= in_dividend;
      r_q[0] <= '0;
      t_q[0] <= in_tag;
      z_q[0] <= (in_divisor == '0);
`ifdef DIV_SIGNED_EN
      nq_q[0] <= sa0_d ^ sb0_d;
      nr_q[0] <= sa0_d;
`endif
      for (int k = 1; k < STAGES; k++) begin
        v_q[k] <= v_q[k-1];
        a_q[k] <= a_c[k-1];
        b_q[k] <= b_q[k-1];
        q_q[k] <= q_c[k-1];
        n_q[k] <= n_q[k-1];
        r_q[k] <= r_c[k-1];
        t_q[k] <= t_q[k-1];
        z_q[k] <= z_q[k-1];
`ifdef DIV_SIGNED_EN
        nq_q[k] <= nq_q[k-1];
        nr_q[k] <= nr_q[k-1];
`endif
      end
      out_v_q <= v_q[STAGES-1];
      if (v_q[STAGES-1]) begin
        quot_q <= q_fix_d;
        rem_q  <= r_fix_d;
        dbz_q  <= z_q[STAGES-1];
        tag_q  <= t_q[STAGES-1];
      end
    end
  end

`ifndef DIV_SIGNED_EN
  logic unused_in_signed;
  assign unused_in_signed = in_signed;
`endif

  assign out_valid       = out_v_q;
  assign out_quotient    = quot_q;
  assign out_remainder   = rem_q;
  assign out_div_by_zero = dbz_q;
  assign out_tag         = tag_q;
endmodule

// File: tb/tb_pipeline_divider_rv.sv
// Bench for pipeline_divider_rv: vector table, latency, backpressure, reset flush and random traffic.
// Signed expectations follow DIV_SIGNED_EN when it is defined for the build.
module tb_pipeline_divider_rv;
  localparam int WIDTH  = 32;
  localparam int STAGES = 8;
  localparam int TAG_W  = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid, in_ready, in_signed;
  logic [WIDTH-1:0] in_dividend, in_divisor;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid, out_ready, out_div_by_zero;
  logic [WIDTH-1:0] out_quotient, out_remainder;
  logic [TAG_W-1:0] out_tag;

  pipeline_divider_rv #(.WIDTH(WIDTH), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_dividend(in_dividend), .in_divisor(in_divisor),
    .in_signed(in_signed), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_quotient(out_quotient), .out_remainder(out_remainder),
    .out_div_by_zero(out_div_by_zero), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dvs;
    logic             sgn;
    logic [TAG_W-1:0] tag;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             z;
  } vec_t;

  typedef struct {
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             z;
    logic [TAG_W-1:0] tag;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic void model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                input logic s, output logic [WIDTH-1:0] q,
                                output logic [WIDTH-1:0] r, output logic z);
    z = (b == 0);
    q = a / b;
    r = a % b;
    if (z) begin
      q = '1;
      r = a;
    end
`ifdef DIV_SIGNED_EN
    else if (s) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = 32'h8000_0000;
        r = '0;
      end else begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
      end
    end
`else
    if (s) q = q;
`endif
  endfunction

  task automatic add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic s,
                     input logic [TAG_W-1:0] t, input logic [WIDTH-1:0] q,
                     input logic [WIDTH-1:0] r, input logic z);
    vec_t v;
    v.dvd = a; v.dvs = b; v.sgn = s; v.tag = t; v.q = q; v.r = r; v.z = z;
    tbl.push_back(v);
  endtask

  task automatic push_exp(input logic [WIDTH-1:0] q, input logic [WIDTH-1:0] r,
                          input logic z, input logic [TAG_W-1:0] t);
    exp_t e;
    e.q = q; e.r = r; e.z = z; e.tag = t;
    sb.push_back(e);
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic s,
                      input logic [TAG_W-1:0] t, input logic [WIDTH-1:0] q,
                      input logic [WIDTH-1:0] r, input logic z);
    int n = 0;
    in_valid = 1'b1; in_dividend = a; in_divisor = b; in_signed = s; in_tag = t;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      total++; bad++;
      $display("FAIL send_timeout: in_ready stuck at 0 for tag %0d", t);
    end else begin
      push_exp(q, r, z, t);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic lat_check(input string nm, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic [TAG_W-1:0] t, input logic [WIDTH-1:0] q,
                           input logic [WIDTH-1:0] r);
    int cyc = 0;
    in_valid = 1'b1; in_dividend = a; in_divisor = b; in_signed = 1'b0; in_tag = t;
    @(posedge clk);
    push_exp(q, r, 1'b0, t);
    #1 in_valid = 1'b0;
    while (!out_valid && cyc < 50) begin
      @(posedge clk);
      #1 cyc++;
    end
    chk(nm, 64'(cyc), 64'(STAGES));
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(posedge clk);
      #1 n++;
    end
    chk(nm, 64'(sb.size()), 64'd0);
  endtask

  // Output monitor: retire against the scoreboard and check hold behaviour under stall.
  exp_t             mon_e;
  logic             hold_v = 1'b0;
  logic [WIDTH-1:0] hold_q, hold_r;
  logic             hold_z;
  logic [TAG_W-1:0] hold_t;

  always @(negedge clk) begin
    if (reset) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        chk("hold_valid", 64'(out_valid), 64'd1);
        chk("hold_quot", 64'(out_quotient), 64'(hold_q));
        chk("hold_rem", 64'(out_remainder), 64'(hold_r));
        chk("hold_dbz", 64'(out_div_by_zero), 64'(hold_z));
        chk("hold_tag", 64'(out_tag), 64'(hold_t));
      end
      if (out_valid && !out_ready) begin
        chk("stall_in_ready", 64'(in_ready), 64'd0);
        hold_v = 1'b1;
        hold_q = out_quotient; hold_r = out_remainder;
        hold_z = out_div_by_zero; hold_t = out_tag;
      end else begin
        hold_v = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_out: got tag %0d expected no result", out_tag);
        end else begin
          mon_e = sb.pop_front();
          chk("out_tag", 64'(out_tag), 64'(mon_e.tag));
          chk("out_quot", 64'(out_quotient), 64'(mon_e.q));
          chk("out_rem", 64'(out_remainder), 64'(mon_e.r));
          chk("out_dbz", 64'(out_div_by_zero), 64'(mon_e.z));
        end
      end
    end
  end

  initial begin
    logic [WIDTH-1:0] a, b, q, r;
    logic             s, z;
    logic             rand_done;
    int               stay_low;

    add(32'd100,        32'd7,          1'b0, 4'd3, 32'd14,         32'd2,        1'b0);
    add(32'h1234,       32'd0,          1'b0, 4'd1, 32'hFFFF_FFFF,  32'h1234,     1'b1);
    add(32'hFFFF_FFF9,  32'd2,          1'b0, 4'd2, 32'h7FFF_FFFC,  32'd1,        1'b0);
    add(32'hFFFF_FFFF,  32'd1,          1'b0, 4'd4, 32'hFFFF_FFFF,  32'd0,        1'b0);
    add(32'd5,          32'd9,          1'b0, 4'd5, 32'd0,          32'd5,        1'b0);
    add(32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0, 4'd6, 32'd1,          32'd0,        1'b0);
    add(32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 4'd7, 32'd0,          32'h8000_0000, 1'b0);
`ifdef DIV_SIGNED_EN
    add(32'hFFFF_FFF9,  32'd2,          1'b1, 4'd8, 32'hFFFF_FFFD,  32'hFFFF_FFFF, 1'b0);
    add(32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 4'd9, 32'h8000_0000,  32'd0,        1'b0);
    add(32'd7,          32'hFFFF_FFFE,  1'b1, 4'd10, 32'hFFFF_FFFD, 32'd1,        1'b0);
    add(32'hFFFF_FFF9,  32'd0,          1'b1, 4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b1);
`else
    add(32'hFFFF_FFF9,  32'd2,          1'b1, 4'd8, 32'h7FFF_FFFC,  32'd1,        1'b0);
    add(32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 4'd9, 32'd0,          32'h8000_0000, 1'b0);
    add(32'd7,          32'hFFFF_FFFE,  1'b1, 4'd10, 32'd0,         32'd7,        1'b0);
    add(32'hFFFF_FFF9,  32'd0,          1'b1, 4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b1);
`endif

    reset = 1'b1; out_ready = 1'b1; in_valid = 1'b0; in_signed = 1'b0;
    in_dividend = '0; in_divisor = '0; in_tag = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_quot", 64'(out_quotient), 64'd0);
    chk("rst_rem", 64'(out_remainder), 64'd0);
    chk("rst_dbz", 64'(out_div_by_zero), 64'd0);
    chk("rst_tag", 64'(out_tag), 64'd0);
    @(posedge clk);
    #1;

    lat_check("latency_basic", 32'd100, 32'd7, 4'd3, 32'd14, 32'd2);
    drain("drain_basic");

    foreach (tbl[i])
      send(tbl[i].dvd, tbl[i].dvs, tbl[i].sgn, tbl[i].tag, tbl[i].q, tbl[i].r, tbl[i].z);
    drain("drain_table");

    // Backpressure: ten back-to-back ops, out_ready low for 5 cycles at the first result.
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          a = 32'd1000 + 32'(i * 37);
          b = 32'(i + 3);
          model(a, b, 1'b0, q, r, z);
          send(a, b, 1'b0, 4'(i), q, r, z);
        end
      end
      begin
        stay_low = 0;
        while (!out_valid && stay_low < 50) begin
          @(posedge clk);
          #1 stay_low++;
        end
        chk("bp_first_result", 64'(out_valid), 64'd1);
        out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain("drain_backpressure");

    // Reset with four operations in flight.
    for (int i = 0; i < 4; i++) begin
      model(32'd500 + 32'(i), 32'd3, 1'b0, q, r, z);
      send(32'd500 + 32'(i), 32'd3, 1'b0, 4'(12 + i), q, r, z);
    end
    reset = 1'b1;
    sb.delete();
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_mid_out_valid", 64'(out_valid), 64'd0);
    stay_low = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) stay_low++;
    end
    chk("rst_mid_quiet", 64'(stay_low), 64'd0);
    @(posedge clk);
    #1;
    lat_check("latency_after_reset", 32'd81, 32'd9, 4'd15, 32'd9, 32'd0);
    drain("drain_reset");

    // Random traffic with random backpressure.
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          case ($urandom_range(0, 3))
            0: b = '0;
            1: b = 32'($urandom_range(1, 15));
            2: b = $urandom;
            default: b = 32'hFFFF_FFFF;
          endcase
          a = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
          s = 1'($urandom_range(0, 1));
          model(a, b, s, q, r, z);
          send(a, b, s, 4'(i), q, r, z);
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1 out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
      end
    join
    drain("drain_random");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
